// File: rtl/pc_fetch_ctrl.sv
// Program counter owner for the fetch stage: next-PC selection (branch > jump > PC+4),
// hazard stalls, and a run/step/halt FSM driven by the debug unit.
module pc_fetch_ctrl #(
    parameter int            NB        = 32,
    parameter logic [NB-1:0] RESET_PC  = '0,
    parameter logic [NB-1:0] HALT_WORD = '1,
    parameter int            NCNT      = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_step_mode,
    input  logic            i_step,
    input  logic            i_clear,
    input  logic            i_stall,
    input  logic            i_branch,
    input  logic [NB-1:0]   i_branch_addr,
    input  logic            i_jump,
    input  logic [NB-1:0]   i_jump_addr,
    input  logic [NB-1:0]   i_instr,
    output logic [NB-1:0]   o_pc,
    output logic [NB-1:0]   o_pc4,
    output logic            o_fetch_valid,
    output logic            o_halted,
    output logic [2:0]      o_state,
    output logic [NCNT-1:0] o_cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP_EXEC = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NB-1:0]   r_pc;
    logic [NB-1:0]   w_pc_nxt;
    logic [NB-1:0]   w_pc4;
    logic [NCNT-1:0] r_cnt;
    logic [NCNT-1:0] w_cnt_nxt;
    logic            w_active;
    logic            w_halt_hit;
    logic            w_fetch_valid;
    logic            w_pc_moves;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_fetch_valid = 1'b0;
        w_pc_moves    = 1'b0;
        w_active      = (r_state == S_RUN) || (r_state == S_STEP_EXEC);
        w_halt_hit    = (i_instr == HALT_WORD);
        w_pc4         = r_pc + NB'(4);

        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = i_step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_STEP_WAIT: begin
                if (i_step) w_state_nxt = S_STEP_EXEC;
            end
            S_RUN, S_STEP_EXEC: begin
                w_fetch_valid = !i_stall && !w_halt_hit;
                // Resolved control flow redirects even a stalled or halting fetch.
                if (i_branch) begin
                    w_pc_nxt   = i_branch_addr;
                    w_pc_moves = 1'b1;
                end else if (i_jump) begin
                    w_pc_nxt   = i_jump_addr;
                    w_pc_moves = 1'b1;
                end else if (i_stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_halt_hit) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_pc_nxt   = w_pc4;
                    w_pc_moves = 1'b1;
                end
                if ((r_state == S_STEP_EXEC) && w_pc_moves) w_state_nxt = S_STEP_WAIT;
                if (r_cnt != '1) w_cnt_nxt = r_cnt + NCNT'(1);
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (i_clear) begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = RESET_PC;
            w_cnt_nxt   = '0;
        end
    end

    assign o_pc          = r_pc;
    assign o_pc4         = w_pc4;
    assign o_fetch_valid = w_fetch_valid;
    assign o_halted      = (r_state == S_HALTED);
    assign o_state       = r_state;
    assign o_cycle_cnt   = r_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, hand-written multi-cycle sequences,
// then randomized cycles checked against a behavioural model of the fetch controller.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step_mode, step, clear, stall, branch, jump;
    logic [31:0] branch_addr, jump_addr, instr;
    logic [31:0] pc, pc4, cycle_cnt;
    logic        fetch_valid, halted;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    pc_fetch_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_clear(clear), .i_stall(stall), .i_branch(branch),
        .i_branch_addr(branch_addr), .i_jump(jump), .i_jump_addr(jump_addr),
        .i_instr(instr), .o_pc(pc), .o_pc4(pc4), .o_fetch_valid(fetch_valid),
        .o_halted(halted), .o_state(state), .o_cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; step_mode = 0; step = 0; clear = 0; stall = 0;
        branch = 0; jump = 0; branch_addr = 0; jump_addr = 0; instr = NOP;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        start, mode, step, clear, stall, br;
        logic [31:0] br_addr;
        logic        jp;
        logic [31:0] jp_addr;
        logic [31:0] instr;
        logic        exp_fv;      // this cycle, before the edge
        logic [31:0] exp_pc;      // after the edge
        logic [2:0]  exp_st;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, m, st, c, sl, b, input logic [31:0] ba,
                       input logic j, input logic [31:0] ja, input logic [31:0] ins,
                       input logic fv, input logic [31:0] epc, input logic [2:0] est,
                       input logic [31:0] ecnt);
        vec_t v;
        v.start = s; v.mode = m; v.step = st; v.clear = c; v.stall = sl; v.br = b;
        v.br_addr = ba; v.jp = j; v.jp_addr = ja; v.instr = ins;
        v.exp_fv = fv; v.exp_pc = epc; v.exp_st = est; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_SWAIT = 2, M_SEXEC = 3, M_HALT = 4;
    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic logic model_fv();
        return (m_st == M_RUN || m_st == M_SEXEC) && !stall && (instr != HALT);
    endfunction

    task automatic model_step();
        bit fetching;
        bit advanced;
        fetching = (m_st == M_RUN || m_st == M_SEXEC);
        advanced = 0;
        if (clear) begin
            m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        end else begin
            if (fetching && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_st == M_IDLE && start) m_st = step_mode ? M_SWAIT : M_RUN;
            else if (m_st == M_SWAIT && step) m_st = M_SEXEC;
            else if (fetching) begin
                if (branch)              begin m_pc = branch_addr; advanced = 1; end
                else if (jump)           begin m_pc = jump_addr;   advanced = 1; end
                else if (stall)          ;
                else if (instr == HALT)  m_st = M_HALT;
                else                     begin m_pc = m_pc + 32'd4; advanced = 1; end
                if (m_st == M_SEXEC && advanced) m_st = M_SWAIT;
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset_pc", pc, 32'h0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", cycle_cnt, 32'd0);
        chk("reset_fv", 32'(fetch_valid), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   st m  sp cl sl br ba     jp ja     instr fv pc     st cnt
        add(1, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  0, 32'h0,  1, 0);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'h4,  1, 1);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'h8,  1, 2);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'hC,  1, 3);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'h10, 1, 4);
        add(0, 0, 0, 0, 1, 0, 0,     0, 0,     NOP,  0, 32'h10, 1, 5);
        add(0, 0, 0, 0, 1, 0, 0,     0, 0,     NOP,  0, 32'h10, 1, 6);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'h14, 1, 7);
        add(0, 0, 0, 0, 0, 0, 0,     1, 32'h20, NOP, 1, 32'h20, 1, 8);
        add(0, 0, 0, 0, 1, 1, 32'h80, 0, 0,    NOP,  0, 32'h80, 1, 9);
        add(0, 0, 0, 0, 0, 1, 32'h80, 1, 32'h40, NOP, 1, 32'h80, 1, 10);
        add(0, 0, 0, 0, 0, 0, 0,     1, 32'hC, NOP,  1, 32'hC,  1, 11);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     HALT, 0, 32'hC,  4, 12);
        add(1, 0, 1, 0, 0, 0, 0,     0, 0,     HALT, 0, 32'hC,  4, 12);
        add(0, 0, 0, 1, 0, 0, 0,     0, 0,     HALT, 0, 32'h0,  0, 0);
        add(1, 1, 0, 0, 0, 0, 0,     0, 0,     NOP,  0, 32'h0,  2, 0);
        add(1, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  0, 32'h0,  2, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0,     NOP,  0, 32'h0,  2, 0);
        add(0, 0, 1, 0, 0, 0, 0,     0, 0,     NOP,  0, 32'h0,  3, 0);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'h4,  2, 1);
        add(0, 0, 1, 0, 0, 0, 0,     0, 0,     NOP,  0, 32'h4,  3, 1);
        add(0, 0, 1, 0, 1, 0, 0,     0, 0,     NOP,  0, 32'h4,  3, 2);
        add(0, 0, 1, 0, 1, 0, 0,     0, 0,     NOP,  0, 32'h4,  3, 3);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  1, 32'h8,  2, 4);
        add(0, 0, 0, 0, 0, 0, 0,     0, 0,     NOP,  0, 32'h8,  2, 4);
        add(1, 0, 0, 1, 0, 0, 0,     0, 0,     NOP,  0, 32'h0,  0, 0);

        foreach (vecs[i]) begin
            start = vecs[i].start; step_mode = vecs[i].mode; step = vecs[i].step;
            clear = vecs[i].clear; stall = vecs[i].stall; branch = vecs[i].br;
            branch_addr = vecs[i].br_addr; jump = vecs[i].jp;
            jump_addr = vecs[i].jp_addr; instr = vecs[i].instr;
            #2;
            chk($sformatf("vec%0d_fv", i), 32'(fetch_valid), 32'(vecs[i].exp_fv));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_st));
            chk($sformatf("vec%0d_cnt", i), cycle_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_st == 3'd4));
            @(negedge clk);
        end
        idle_inputs();

        // Asynchronous reset in the middle of a run cycle.
        start = 1;
        @(negedge clk);
        start = 0; jump = 1; jump_addr = 32'h44;
        @(negedge clk);
        jump = 0;
        chk("midrun_pc", pc, 32'h44);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_cnt", cycle_cnt, 32'd0);
        chk("async_rst_fv", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PC wrap from the top of the address space.
        start = 1;
        @(negedge clk);
        start = 0; branch = 1; branch_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        branch = 0;
        #1;
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        @(posedge clk);
        #1;
        chk("wrap_pc_zero", pc, 32'h0);
        @(negedge clk);

        // Randomized cycles against the model.
        do_reset();
        m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            start       = ($urandom_range(0, 5) == 0);
            step_mode   = $urandom_range(0, 1) == 1;
            step        = ($urandom_range(0, 2) == 0);
            clear       = ($urandom_range(0, 39) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 7) == 0);
            jump        = ($urandom_range(0, 7) == 0);
            branch_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            jump_addr   = $urandom() & 32'hFFFF_FFFC;
            instr       = ($urandom_range(0, 15) == 0) ? HALT : $urandom_range(0, 32'h7FFF_FFFF);
            #2;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pc4", pc4, m_pc + 32'd4);
            chk("rnd_state", 32'(state), 32'(m_st));
            chk("rnd_cnt", cycle_cnt, m_cnt);
            chk("rnd_halted", 32'(halted), 32'(m_st == M_HALT));
            chk("rnd_fv", 32'(fetch_valid), 32'(model_fv()));
            model_step();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
